// File: rtl/lattice_label_cpu.sv
// Streamed-instruction CPU with LEVELS ordered security labels on every register and
// one labelled output channel per level; implicit flow through SKIP_NEXT is tracked as taint.
module lattice_label_cpu #(
  parameter  int DATA_W = 8,
  parameter  int LEVELS = 4,
  parameter  int NUM_GP = 4,
  localparam int LBL_W  = (LEVELS < 2) ? 1 : $clog2(LEVELS),
  localparam int REG_W  = $clog2(1 + 2*LEVELS + NUM_GP)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       instr_valid,
  output logic                       instr_ready,
  input  logic [3+3*REG_W-1:0]       instr,
  input  logic [LEVELS*DATA_W-1:0]   in_data,
  output logic [LEVELS*DATA_W-1:0]   out_data,
  output logic [LEVELS*LBL_W-1:0]    out_label,
  output logic [LEVELS-1:0]          out_valid,
  input  logic [LEVELS-1:0]          out_ready,
  output logic                       violation,
  output logic                       illegal,
  output logic [7:0]                 viol_count
);
  localparam int OUT_BASE = 1 + LEVELS;
  localparam int GP_BASE  = 1 + 2*LEVELS;
  localparam int NREGS    = GP_BASE + NUM_GP;

  logic [NUM_GP-1:0][DATA_W-1:0] gp_val;
  logic [NUM_GP-1:0][LBL_W-1:0]  gp_lbl;
  logic [LEVELS-1:0][DATA_W-1:0] ov;
  logic [LEVELS-1:0][LBL_W-1:0]  ol;
  logic [LBL_W-1:0]              taint;
  logic                          skip;

  logic [2:0]       op;
  logic [REG_W-1:0] s1, s2, d;
  assign {op, s1, s2, d} = instr;
  assign out_data  = ov;
  assign out_label = ol;

  function automatic logic [LBL_W-1:0] lmax(input logic [LBL_W-1:0] a, input logic [LBL_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Unified register-file read: ZERO and out-of-map indices fall through to 0/label 0.
  function automatic logic [DATA_W+LBL_W-1:0] rd(input logic [REG_W-1:0] idx);
    logic [DATA_W+LBL_W-1:0] r;
    r = '0;
    for (int k = 0; k < LEVELS; k++) begin
      if (int'(idx) == 1 + k)        r = {in_data[k*DATA_W +: DATA_W], LBL_W'(k)};
      if (int'(idx) == OUT_BASE + k) r = {ov[k], ol[k]};
    end
    for (int g = 0; g < NUM_GP; g++)
      if (int'(idx) == GP_BASE + g)  r = {gp_val[g], gp_lbl[g]};
    return r;
  endfunction

  logic [DATA_W-1:0] v1, v2, res_v;
  logic [LBL_W-1:0]  l1, l2, res_l, wr_l, cls;
  logic              bad, writes, accept, exec, viol_now;
  logic [NUM_GP-1:0] gp_we;
  logic [LEVELS-1:0] out_we;

  assign accept = instr_valid && instr_ready;
  assign exec   = accept && !skip;

  always_comb begin
    {v1, l1} = rd(s1);
    {v2, l2} = rd(s2);
    cls   = (int'(s2[LBL_W-1:0]) > LEVELS - 1) ? LBL_W'(LEVELS - 1) : s2[LBL_W-1:0];
    res_v = v1;
    res_l = l1;
    case (op)
      3'd1:    res_v = ~v1;
      3'd2:    begin res_v = v1 & v2; res_l = lmax(l1, l2); end
      3'd3:    begin res_v = v1 | v2; res_l = lmax(l1, l2); end
      3'd4:    res_l = lmax(l1, cls);
      3'd5:    begin res_v = DATA_W'(l1); res_l = '0; end
      default: ;
    endcase
    wr_l = lmax(res_l, taint);
    // Only fields the opcode actually uses as register indices are range-checked.
    bad = (op == 3'd7) || (int'(s1) >= NREGS) ||
          ((op == 3'd2 || op == 3'd3) && int'(s2) >= NREGS) ||
          (op != 3'd6 && int'(d) >= NREGS);
    writes = exec && !bad && op != 3'd6;
  end

  always_comb begin
    gp_we    = '0;
    out_we   = '0;
    viol_now = 1'b0;
    if (writes) begin
      for (int g = 0; g < NUM_GP; g++)
        if (int'(d) == GP_BASE + g) gp_we[g] = 1'b1;
      for (int k = 0; k < LEVELS; k++)
        if (int'(d) == OUT_BASE + k) begin
          if (wr_l > LBL_W'(k)) viol_now  = 1'b1;
          else                  out_we[k] = 1'b1;
        end
    end
  end

  // Back-pressure only when the target channel is still full; skipped instructions never stall.
  always_comb begin
    instr_ready = 1'b1;
    for (int k = 0; k < LEVELS; k++)
      if (int'(d) == OUT_BASE + k && !skip && out_valid[k] && !out_ready[k]) instr_ready = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gp_val     <= '0;
      gp_lbl     <= '0;
      ov         <= '0;
      ol         <= '0;
      out_valid  <= '0;
      taint      <= '0;
      skip       <= 1'b0;
      violation  <= 1'b0;
      illegal    <= 1'b0;
      viol_count <= '0;
    end else begin
      violation <= viol_now;
      illegal   <= exec && bad;
      if (viol_now && viol_count != 8'hFF) viol_count <= viol_count + 8'd1;
      if (accept) begin
        // Taint lives for exactly one accepted instruction unless chained by another SKIP_NEXT.
        if (exec && !bad && op == 3'd6) begin
          taint <= lmax(taint, l1);
          skip  <= |v1;
        end else begin
          taint <= '0;
          skip  <= 1'b0;
        end
      end
      for (int g = 0; g < NUM_GP; g++)
        if (gp_we[g]) begin
          gp_val[g] <= res_v;
          gp_lbl[g] <= wr_l;
        end
      for (int k = 0; k < LEVELS; k++)
        if (out_we[k]) begin
          ov[k]        <= res_v;
          ol[k]        <= wr_l;
          out_valid[k] <= 1'b1;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
    end
  end
endmodule

// File: tb/tb_lattice_label_cpu.sv
// Bench for lattice_label_cpu: directed scenarios plus random streams against an
// array-based reference model of the label rules.
module tb_lattice_label_cpu;
  localparam int DATA_W = 8, LEVELS = 4, NUM_GP = 4, LBL_W = 2, REG_W = 4;
  localparam int IW = 3 + 3*REG_W;
  localparam int NREG = 1 + 2*LEVELS + NUM_GP;
  localparam int MASK = (1 << DATA_W) - 1;
  localparam int RA = 2*LEVELS + 1, RB = 2*LEVELS + 2;
  localparam logic [LEVELS-1:0] ALL = '1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic instr_valid = 1'b0, instr_ready;
  logic [IW-1:0] instr = '0;
  logic [LEVELS*DATA_W-1:0] in_data = '0, out_data;
  logic [LEVELS*LBL_W-1:0]  out_label;
  logic [LEVELS-1:0]        out_valid, out_ready = '0;
  logic                     violation, illegal;
  logic [7:0]               viol_count;

  always #5 clk = ~clk;

  lattice_label_cpu #(.DATA_W(DATA_W), .LEVELS(LEVELS), .NUM_GP(NUM_GP)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .in_data(in_data), .out_data(out_data), .out_label(out_label),
    .out_valid(out_valid), .out_ready(out_ready), .violation(violation),
    .illegal(illegal), .viol_count(viol_count));

  int gv[NUM_GP], gl[NUM_GP], mov[LEVELS], mol[LEVELS], movld[LEVELS];
  int taint, skip, vcnt, e_viol, e_ill;
  int n_checks = 0, n_err = 0;
  logic obs_ready, exp_ready;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int IN(input int k);  return 1 + k;          endfunction
  function automatic int OUT(input int k); return 1 + LEVELS + k; endfunction

  function automatic logic [IW-1:0] mk(input int op, input int s1, input int s2, input int d);
    return {3'(op), REG_W'(s1), REG_W'(s2), REG_W'(d)};
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < NUM_GP; i++) begin gv[i] = 0; gl[i] = 0; end
    for (int k = 0; k < LEVELS; k++) begin mov[k] = 0; mol[k] = 0; movld[k] = 0; end
    taint = 0; skip = 0; vcnt = 0; e_viol = 0; e_ill = 0;
  endfunction

  function automatic void rd(input int idx, output int v, output int l);
    v = 0; l = 0;
    if (idx >= 1 && idx <= LEVELS) begin
      v = int'(in_data[(idx-1)*DATA_W +: DATA_W]); l = idx - 1;
    end else if (idx > LEVELS && idx <= 2*LEVELS) begin
      v = mov[idx-LEVELS-1]; l = mol[idx-LEVELS-1];
    end else if (idx > 2*LEVELS && idx < NREG) begin
      v = gv[idx-2*LEVELS-1]; l = gl[idx-2*LEVELS-1];
    end
  endfunction

  function automatic logic m_ready(input logic [IW-1:0] ins, input logic [LEVELS-1:0] ordy);
    int d;
    d = int'(ins[REG_W-1:0]);
    if (skip == 0 && d > LEVELS && d <= 2*LEVELS)
      if (movld[d-LEVELS-1] != 0 && !ordy[d-LEVELS-1]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void m_step(input logic v, input logic [IW-1:0] ins, input logic [LEVELS-1:0] ordy);
    int op, s1, s2, d, v1, l1, v2, l2, rv, rl, wl, k, bad;
    int wrote[LEVELS];
    e_viol = 0; e_ill = 0;
    for (int i = 0; i < LEVELS; i++) wrote[i] = 0;
    if (v && m_ready(ins, ordy)) begin
      op = int'(ins[IW-1 -: 3]); s1 = int'(ins[3*REG_W-1 -: REG_W]);
      s2 = int'(ins[2*REG_W-1 -: REG_W]); d = int'(ins[REG_W-1:0]);
      if (skip != 0) begin
        skip = 0; taint = 0;
      end else begin
        rd(s1, v1, l1); rd(s2, v2, l2);
        bad = int'(op == 7 || s1 >= NREG || ((op == 2 || op == 3) && s2 >= NREG) || (op != 6 && d >= NREG));
        e_ill = bad;
        if (bad == 0 && op == 6) begin
          taint = imax(taint, l1); skip = int'(v1 != 0);
        end else begin
          if (bad == 0) begin
            rv = v1; rl = l1;
            case (op)
              1: rv = ~v1 & MASK;
              2: begin rv = v1 & v2; rl = imax(l1, l2); end
              3: begin rv = v1 | v2; rl = imax(l1, l2); end
              4: rl = imax(l1, (s2 % (1 << LBL_W) > LEVELS-1) ? LEVELS-1 : s2 % (1 << LBL_W));
              5: begin rv = l1; rl = 0; end
              default: ;
            endcase
            wl = imax(rl, taint);
            if (d > 2*LEVELS) begin
              gv[d-2*LEVELS-1] = rv; gl[d-2*LEVELS-1] = wl;
            end else if (d > LEVELS) begin
              k = d - LEVELS - 1;
              if (wl > k) begin e_viol = 1; if (vcnt < 255) vcnt++; end
              else begin mov[k] = rv; mol[k] = wl; movld[k] = 1; wrote[k] = 1; end
            end
          end
          taint = 0; skip = 0;
        end
      end
    end
    for (int i = 0; i < LEVELS; i++) if (wrote[i] == 0 && ordy[i]) movld[i] = 0;
  endfunction

  function automatic logic [LEVELS*DATA_W-1:0] e_od();
    logic [LEVELS*DATA_W-1:0] r;
    for (int k = 0; k < LEVELS; k++) r[k*DATA_W +: DATA_W] = DATA_W'(mov[k]);
    return r;
  endfunction
  function automatic logic [LEVELS*LBL_W-1:0] e_ol();
    logic [LEVELS*LBL_W-1:0] r;
    for (int k = 0; k < LEVELS; k++) r[k*LBL_W +: LBL_W] = LBL_W'(mol[k]);
    return r;
  endfunction
  function automatic logic [LEVELS-1:0] e_ov();
    logic [LEVELS-1:0] r;
    for (int k = 0; k < LEVELS; k++) r[k] = (movld[k] != 0);
    return r;
  endfunction

  task automatic cycle(input logic v, input logic [IW-1:0] ins, input logic [LEVELS-1:0] ordy);
    @(negedge clk);
    instr_valid = v; instr = ins; out_ready = ordy;
    #1;
    obs_ready = instr_ready;
    exp_ready = m_ready(ins, ordy);
    @(posedge clk);
    m_step(v, ins, ordy);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; out_ready = '0;
    m_clear();
    #2;
    n_checks++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    n_checks++; if (out_label !== '0) begin n_err++; $display("FAIL reset_out_label got=%h exp=0", out_label); end
    n_checks++; if (out_valid !== '0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (violation !== 1'b0 || illegal !== 1'b0) begin n_err++; $display("FAIL reset_pulses got=%b%b exp=00", violation, illegal); end
    n_checks++; if (viol_count !== 8'd0) begin n_err++; $display("FAIL reset_viol_count got=%0d exp=0", viol_count); end
    n_checks++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", instr_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_flow();
    in_data = {8'h44, 8'hA5, 8'h5A, 8'h01};
    cycle(1, mk(0, IN(2), 0, RA), '0);
    cycle(1, mk(0, RA, 0, OUT(3)), '0);
    n_checks++; if (out_data[31:24] !== 8'hA5) begin n_err++; $display("FAIL flow_data got=%h exp=a5", out_data[31:24]); end
    n_checks++; if (out_label[7:6] !== 2'd2) begin n_err++; $display("FAIL flow_label got=%0d exp=2", out_label[7:6]); end
    n_checks++; if (out_valid !== 4'b1000) begin n_err++; $display("FAIL flow_valid got=%b exp=1000", out_valid); end
  endtask

  task automatic test_violation();
    cycle(1, mk(0, IN(3), 0, RA), '0);
    cycle(1, mk(0, RA, 0, OUT(1)), '0);
    n_checks++; if (violation !== 1'b1) begin n_err++; $display("FAIL viol_pulse got=%b exp=1", violation); end
    n_checks++; if (out_valid[1] !== 1'b0) begin n_err++; $display("FAIL viol_valid1 got=%b exp=0", out_valid[1]); end
    n_checks++; if (viol_count !== 8'd1) begin n_err++; $display("FAIL viol_count got=%0d exp=1", viol_count); end
    cycle(0, '0, '0);
    n_checks++; if (violation !== 1'b0) begin n_err++; $display("FAIL viol_one_cycle got=%b exp=0", violation); end
  endtask

  task automatic test_skip();
    in_data = {8'h44, 8'h33, 8'h5A, 8'h01};
    cycle(1, mk(0, IN(1), 0, RB), '0);      // B = 5A label 1
    cycle(1, mk(0, IN(0), 0, RA), '0);      // A = 1 label 0
    cycle(1, mk(4, RA, 3, RA), '0);         // A = 1 label 3
    cycle(1, mk(6, RA, 0, 0), '0);
    cycle(1, mk(0, 0, 0, RB), '0);          // skipped
    cycle(1, mk(0, 0, 0, OUT(0)), '0);
    n_checks++; if (out_valid[0] !== 1'b1 || violation !== 1'b0) begin n_err++; $display("FAIL skip_out0 valid=%b viol=%b exp=1,0", out_valid[0], violation); end
    n_checks++; if (out_label[1:0] !== 2'd0 || out_data[7:0] !== 8'h00) begin n_err++; $display("FAIL skip_out0_val got=%h/%0d exp=00/0", out_data[7:0], out_label[1:0]); end
    cycle(1, mk(0, RB, 0, OUT(2)), '0);
    n_checks++; if (out_data[23:16] !== 8'h5A || out_label[5:4] !== 2'd1) begin n_err++; $display("FAIL skip_b_kept got=%h/%0d exp=5a/1", out_data[23:16], out_label[5:4]); end
    cycle(1, mk(4, 0, 3, RA), ALL);         // A = 0 label 3
    cycle(1, mk(6, RA, 0, 0), ALL);
    cycle(1, mk(0, 0, 0, OUT(0)), ALL);
    n_checks++; if (violation !== 1'b1) begin n_err++; $display("FAIL taint_viol got=%b exp=1", violation); end
    n_checks++; if (out_valid[0] !== 1'b0) begin n_err++; $display("FAIL taint_nowrite got=%b exp=0", out_valid[0]); end
    n_checks++; if (viol_count !== 8'd2) begin n_err++; $display("FAIL taint_count got=%0d exp=2", viol_count); end
  endtask

  task automatic test_stall();
    in_data = {8'h44, 8'h33, 8'h5A, 8'h01};
    cycle(1, mk(0, IN(0), 0, OUT(2)), '0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, mk(0, IN(1), 0, OUT(2)), '0);
      n_checks++; if (obs_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready i=%0d got=%b exp=0", i, obs_ready); end
      n_checks++; if (out_data[23:16] !== 8'h01) begin n_err++; $display("FAIL stall_hold i=%0d got=%h exp=01", i, out_data[23:16]); end
    end
    cycle(1, mk(0, IN(1), 0, OUT(2)), 4'b0100);
    n_checks++; if (obs_ready !== 1'b1) begin n_err++; $display("FAIL stall_release got=%b exp=1", obs_ready); end
    n_checks++; if (out_valid[2] !== 1'b1 || out_data[23:16] !== 8'h5A) begin n_err++; $display("FAIL stall_new got=%b/%h exp=1/5a", out_valid[2], out_data[23:16]); end
    cycle(0, '0, 4'b0100);
    n_checks++; if (out_valid[2] !== 1'b0) begin n_err++; $display("FAIL stall_drain got=%b exp=0", out_valid[2]); end
  endtask

  task automatic test_saturate();
    cycle(1, mk(0, IN(3), 0, RA), ALL);
    for (int i = 0; i < 300; i++) begin
      cycle(1, mk(0, RA, 0, OUT(0)), ALL);
      if (i == 99) begin
        n_checks++; if (viol_count !== 8'(vcnt)) begin n_err++; $display("FAIL sat_mid got=%0d exp=%0d", viol_count, vcnt); end
      end
    end
    n_checks++; if (viol_count !== 8'd255) begin n_err++; $display("FAIL sat_final got=%0d exp=255", viol_count); end
  endtask

  task automatic test_illegal();
    in_data = {8'hC3, 8'h22, 8'h5A, 8'h01};
    cycle(1, mk(0, IN(3), 0, RA), ALL);
    cycle(1, mk(7, IN(0), 0, OUT(0)), ALL);
    n_checks++; if (illegal !== 1'b1 || out_valid[0] !== 1'b0) begin n_err++; $display("FAIL ill_op7 ill=%b valid0=%b exp=1,0", illegal, out_valid[0]); end
    cycle(1, mk(0, 15, 0, RA), ALL);
    n_checks++; if (illegal !== 1'b1) begin n_err++; $display("FAIL ill_src15 got=%b exp=1", illegal); end
    cycle(1, mk(0, IN(0), 0, 15), ALL);
    n_checks++; if (illegal !== 1'b1 || viol_count !== 8'd255) begin n_err++; $display("FAIL ill_dst15 ill=%b cnt=%0d exp=1,255", illegal, viol_count); end
    cycle(0, '0, ALL);
    n_checks++; if (illegal !== 1'b0) begin n_err++; $display("FAIL ill_pulse got=%b exp=0", illegal); end
    cycle(1, mk(0, RA, 0, OUT(3)), '0);
    n_checks++; if (out_data[31:24] !== 8'hC3 || out_label[7:6] !== 2'd3 || out_valid[3] !== 1'b1) begin
      n_err++; $display("FAIL ill_a_kept got=%h/%0d/%b exp=c3/3/1", out_data[31:24], out_label[7:6], out_valid[3]); end
    cycle(0, '0, ALL);
  endtask

  task automatic test_random(input int n);
    logic [IW-1:0] ins;
    int r1, r2, rd_;
    for (int c = 0; c < n; c++) begin
      in_data = {$urandom, $urandom};
      r1  = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 15) : $urandom_range(0, 12);
      r2  = $urandom_range(0, 12);
      rd_ = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 15) : $urandom_range(0, 12);
      ins = mk($urandom_range(0, 7), r1, r2, rd_);
      cycle($urandom_range(0, 4) != 0, ins, LEVELS'($urandom));
      n_checks++; if (obs_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, obs_ready, exp_ready); end
      n_checks++; if (out_data !== e_od()) begin n_err++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, out_data, e_od()); end
      n_checks++; if (out_label !== e_ol()) begin n_err++; $display("FAIL rnd_label c=%0d got=%h exp=%h", c, out_label, e_ol()); end
      n_checks++; if (out_valid !== e_ov()) begin n_err++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, e_ov()); end
      n_checks++; if (violation !== 1'(e_viol) || illegal !== 1'(e_ill)) begin n_err++; $display("FAIL rnd_pulses c=%0d got=%b%b exp=%0d%0d", c, violation, illegal, e_viol, e_ill); end
      n_checks++; if (viol_count !== 8'(vcnt)) begin n_err++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, viol_count, vcnt); end
    end
  endtask

  initial begin
    m_clear();
    test_reset();
    test_flow();
    test_violation();
    test_skip();
    test_stall();
    test_saturate();
    test_illegal();
    test_random(300);
    test_reset();
    test_random(300);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
